// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - divider state encodings and stall-handshake constants
package div_pkg;

   typedef enum logic [1:0] {
      DIV_FREE   = 2'b00,
      DIV_BYZERO = 2'b01,
      DIV_ON     = 2'b10,
      DIV_END    = 2'b11
   } div_state_t;

   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;
   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div.sv
// rtl/div.sv - multi-cycle restoring divider for DIV/DIVU, one quotient bit per clock
module div
   import div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o
);

   localparam int CW = $clog2(WIDTH) + 1;

   div_state_t         state, state_n;
   logic [CW-1:0]      cnt, cnt_n;
   logic [2*WIDTH:0]   dvd, dvd_n;
   logic [WIDTH-1:0]   divisor, divisor_n;
   logic               sgn_div, sgn_div_n;
   logic               sgn1, sgn1_n;
   logic               sgn2, sgn2_n;
   logic [2*WIDTH-1:0] result_n;
   logic               ready_n;

   logic               accept, hold;
   logic [WIDTH:0]     diff;
   logic [WIDTH-1:0]   mag1, mag2, q_mag, r_mag, q_fix, r_fix;

   assign accept = (start_i == DIV_START) && !annul_i;
   assign hold   = !((start_i == DIV_STOP) || annul_i);

   assign mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
   assign mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

   // 33-bit trial subtraction: the top bit is the borrow that rejects the step
   assign diff  = dvd[2*WIDTH:WIDTH] - {1'b0, divisor};
   assign q_mag = dvd[WIDTH-1:0];
   assign r_mag = dvd[2*WIDTH:WIDTH+1];
   assign q_fix = (sgn_div && (sgn1 ^ sgn2)) ? -q_mag : q_mag;
   assign r_fix = (sgn_div && sgn1) ? -r_mag : r_mag;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= DIV_FREE;
         cnt      <= '0;
         dvd      <= '0;
         divisor  <= '0;
         sgn_div  <= 1'b0;
         sgn1     <= 1'b0;
         sgn2     <= 1'b0;
         result_o <= '0;
         ready_o  <= DIV_RESULT_NOT_READY;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         dvd      <= dvd_n;
         divisor  <= divisor_n;
         sgn_div  <= sgn_div_n;
         sgn1     <= sgn1_n;
         sgn2     <= sgn2_n;
         result_o <= result_n;
         ready_o  <= ready_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      dvd_n     = dvd;
      divisor_n = divisor;
      sgn_div_n = sgn_div;
      sgn1_n    = sgn1;
      sgn2_n    = sgn2;
      result_n  = result_o;
      ready_n   = ready_o;
      case (state)
         DIV_FREE: begin
            result_n = '0;
            ready_n  = DIV_RESULT_NOT_READY;
            if (accept) begin
               if (opdata2_i == '0) begin
                  state_n = DIV_BYZERO;
               end else begin
                  state_n   = DIV_ON;
                  cnt_n     = '0;
                  dvd_n     = {{WIDTH{1'b0}}, mag1, 1'b0};
                  divisor_n = mag2;
                  sgn_div_n = signed_div_i;
                  sgn1_n    = opdata1_i[WIDTH-1];
                  sgn2_n    = opdata2_i[WIDTH-1];
               end
            end
         end
         DIV_BYZERO: begin
            state_n  = DIV_END;
            result_n = '0;
            ready_n  = DIV_RESULT_READY;
         end
         DIV_ON: begin
            if (!hold) begin
               state_n  = DIV_FREE;
               result_n = '0;
               ready_n  = DIV_RESULT_NOT_READY;
            end else if (cnt != CW'(WIDTH)) begin
               if (diff[WIDTH])
                  dvd_n = {dvd[2*WIDTH-1:0], 1'b0};
               else
                  dvd_n = {diff[WIDTH-1:0], dvd[WIDTH-1:0], 1'b1};
               cnt_n = cnt + CW'(1);
            end else begin
               state_n  = DIV_END;
               result_n = {r_fix, q_fix};
               ready_n  = DIV_RESULT_READY;
            end
         end
         DIV_END: begin
            if (!hold) begin
               state_n  = DIV_FREE;
               result_n = '0;
               ready_n  = DIV_RESULT_NOT_READY;
            end
         end
         default: state_n = DIV_FREE;
      endcase
   end

endmodule
